// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Scrub support is compiled in only when DMEM_ARB_SCRUB_EN is defined.
package dmem_arb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_WIDTH  = 4;
    localparam int DEF_MAX_WAIT   = 4;

    // state | meaning
    // ARB   | CPU and debug share the port, starvation counter active
    // SCRUB | sequencer owns the port and zero-fills every address
    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_SCRUB = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_CPU   = 2'd1,
        OWN_DBG   = 2'd2,
        OWN_SCRUB = 2'd3
    } owner_t;

    // Counter width able to hold 0..max_wait inclusive.
    function automatic int wait_w(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/dmem_scrub_seq.sv
// Zero-fill sequencer: walks every memory address once while enabled and
// pulses done the cycle after the last write. Only built with DMEM_ARB_SCRUB_EN.
module dmem_scrub_seq
    import dmem_arb_pkg::*;
#(
    parameter int MEM_WIDTH = DEF_MEM_WIDTH
) (
    input  logic                 clka,
    input  logic                 reset,
    input  logic                 i_en,
    output logic [MEM_WIDTH-1:0] o_addr,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done
);

    logic [MEM_WIDTH-1:0] r_cnt;
    logic                 r_done;
    logic                 w_last;

    assign w_last = i_en && (&r_cnt);

    // Address counter wraps to zero after the top address, ready for the next run.
    always_ff @(posedge clka) begin
        if (reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (i_en) begin
                r_cnt <= r_cnt + MEM_WIDTH'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_addr = r_cnt;
    assign o_last = w_last;
    assign o_busy = i_en;
    assign o_done = r_done;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter shared by the CPU MEM stage and the debug
// unit. CPU has priority; debug gets a forced slot after MAX_WAIT denied
// cycles. Optional zero-fill scrub is enabled by defining DMEM_ARB_SCRUB_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [MEM_WIDTH-1:0]  i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_cpu_stall,
    input  logic                  i_dbg_req,
    input  logic                  i_dbg_we,
    input  logic [MEM_WIDTH-1:0]  i_dbg_addr,
    input  logic [DATA_WIDTH-1:0] i_dbg_wdata,
    output logic                  o_dbg_gnt,
    output logic                  o_dbg_ack,
    output logic [DATA_WIDTH-1:0] o_dbg_rdata,
    input  logic                  i_scrub_start,
    output logic                  o_scrub_busy,
    output logic                  o_scrub_done,
    output logic                  o_mem_we,
    output logic [MEM_WIDTH-1:0]  o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_din,
    input  logic [DATA_WIDTH-1:0] i_mem_dout
);

    localparam int                WAIT_W   = wait_w(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    owner_t                w_owner;
    logic [WAIT_W-1:0]     r_wait_cnt;
    logic                  w_starve;
    logic                  w_dbg_gnt;
    logic                  r_dbg_ack;
    logic [DATA_WIDTH-1:0] r_dbg_rdata;

`ifdef DMEM_ARB_SCRUB_EN
    logic                 w_scrub_en;
    logic                 w_scrub_last;
    logic [MEM_WIDTH-1:0] w_scrub_addr;

    assign w_scrub_en = (r_state == ST_SCRUB);

    dmem_scrub_seq #(
        .MEM_WIDTH (MEM_WIDTH)
    ) u_scrub (
        .clka   (clka),
        .reset  (reset),
        .i_en   (w_scrub_en),
        .o_addr (w_scrub_addr),
        .o_last (w_scrub_last),
        .o_busy (o_scrub_busy),
        .o_done (o_scrub_done)
    );
`else
    logic w_unused_scrub;

    assign w_unused_scrub = i_scrub_start;
    assign o_scrub_busy   = 1'b0;
    assign o_scrub_done   = 1'b0;
`endif

    assign w_starve = (r_wait_cnt == WAIT_MAX);

    // State register; reset always lands in ARB, aborting any scrub.
    always_ff @(posedge clka) begin
        if (reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle port owner; nobody owns the port during reset.
    always_comb begin
        w_state_nxt = r_state;
        w_owner     = OWN_NONE;
        case (r_state)
            ST_ARB: begin
                if (i_dbg_req && (w_starve || !i_cpu_req)) begin
                    w_owner = OWN_DBG;
                end else if (i_cpu_req) begin
                    w_owner = OWN_CPU;
                end
`ifdef DMEM_ARB_SCRUB_EN
                if (i_scrub_start) begin
                    w_state_nxt = ST_SCRUB;
                end
`endif
            end
`ifdef DMEM_ARB_SCRUB_EN
            ST_SCRUB: begin
                w_owner = OWN_SCRUB;
                if (w_scrub_last) begin
                    w_state_nxt = ST_ARB;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
        if (reset) begin
            w_owner = OWN_NONE;
        end
    end

    // Steer the owner's request onto the memory pins; idle port drives zeros.
    always_comb begin
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_mem_din  = '0;
        case (w_owner)
            OWN_CPU: begin
                o_mem_we   = i_cpu_we;
                o_mem_addr = i_cpu_addr;
                o_mem_din  = i_cpu_wdata;
            end
            OWN_DBG: begin
                o_mem_we   = i_dbg_we;
                o_mem_addr = i_dbg_addr;
                o_mem_din  = i_dbg_wdata;
            end
`ifdef DMEM_ARB_SCRUB_EN
            OWN_SCRUB: begin
                o_mem_we   = 1'b1;
                o_mem_addr = w_scrub_addr;
                o_mem_din  = '0;
            end
`endif
            default: begin
                o_mem_we = 1'b0;
            end
        endcase
    end

    assign w_dbg_gnt   = (w_owner == OWN_DBG);
    assign o_dbg_gnt   = w_dbg_gnt;
    assign o_cpu_stall = !reset && i_cpu_req && (w_owner != OWN_CPU);
    assign o_cpu_rdata = i_mem_dout;

    // Count consecutive denied debug cycles; held still while scrubbing.
    always_ff @(posedge clka) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_SCRUB) begin
            r_wait_cnt <= r_wait_cnt;
        end else if (w_dbg_gnt || !i_dbg_req) begin
            r_wait_cnt <= '0;
        end else if (!w_starve) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
        end
    end

    // Debug acknowledge pulse and read-data capture one cycle after the grant.
    always_ff @(posedge clka) begin
        if (reset) begin
            r_dbg_ack   <= 1'b0;
            r_dbg_rdata <= '0;
        end else begin
            r_dbg_ack <= w_dbg_gnt;
            if (w_dbg_gnt && !i_dbg_we) begin
                r_dbg_rdata <= i_mem_dout;
            end
        end
    end

    assign o_dbg_ack   = r_dbg_ack;
    assign o_dbg_rdata = r_dbg_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single-port data memory (DATA_WIDTH x 2**MEM_WIDTH, combinational read, write on clka). It shares the one memory port between the MIPS MEM stage (CPU) and the debug/UART unit, and an optional scrub sequencer that zero-fills the memory on command. It sits between both requesters and the memory's wea/addra/dina/douta pins.

## Interface
- DATA_WIDTH, 32, memory word width
- MEM_WIDTH, 4, memory address width (depth 2**MEM_WIDTH)
- MAX_WAIT, 4, consecutive denied debug cycles before debug is forced a slot (>=1)

Ports:
- clka  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU memory access this cycle
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  MEM_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_rdata  out  DATA_WIDTH  CPU read data, combinational
- cpu_stall  out  1  CPU access not served this cycle, hold request
- dbg_req  in  1  debug access request, held until dbg_gnt
- dbg_we  in  1  debug write / read
- dbg_addr  in  MEM_WIDTH  debug address
- dbg_wdata  in  DATA_WIDTH  debug write data
- dbg_gnt  out  1  debug access performed this cycle
- dbg_ack  out  1  registered pulse, one cycle after dbg_gnt
- dbg_rdata  out  DATA_WIDTH  registered read data, valid with dbg_ack
- scrub_start  in  1  start zero-fill (only with DMEM_ARB_SCRUB_EN)
- scrub_busy  out  1  scrub in progress
- scrub_done  out  1  one-cycle pulse after last scrub write
- mem_we, mem_addr, mem_din  out  1/MEM_WIDTH/DATA_WIDTH  to memory
- mem_dout  in  DATA_WIDTH  from memory (combinational)

## Operation
- States: ARB, SCRUB. Reset -> ARB.
- Owner per cycle in ARB (combinational): starve = (wait_cnt == MAX_WAIT).
  - If dbg_req && (starve || !cpu_req): debug owns the port. dbg_gnt=1.
  - Else if cpu_req: CPU owns the port.
  - Else idle: mem_we=0, mem_addr=0, mem_din=0.
- The owner's we/addr/wdata drive mem_*. cpu_rdata = mem_dout, always.
- cpu_stall = cpu_req && CPU not owner. Covers SCRUB and a starvation slot.
- wait_cnt: cleared on dbg_gnt or !dbg_req. Otherwise, while dbg_req && !dbg_gnt, it increments and saturates at MAX_WAIT.
- On dbg_gnt: register dbg_ack<=1. If it was a read, also register dbg_rdata<=mem_dout. dbg_rdata holds its value until the next debug read.
- SCRUB: scrub_cnt runs 0..2**MEM_WIDTH-1, one write per cycle with mem_we=1, mem_addr=scrub_cnt, mem_din=0.
  - dbg_gnt=0 during SCRUB. wait_cnt is frozen.
  - After address 2**MEM_WIDTH-1 is written: next state ARB, scrub_done pulses one cycle.
- ARB->SCRUB on scrub_start, which takes effect the following cycle. scrub_start is ignored in SCRUB.

## Timing
- Reset values: dbg_ack=0, dbg_rdata=0, scrub_busy=0, scrub_done=0, wait_cnt=0, scrub_cnt=0.
- While reset=1: mem_we=0, dbg_gnt=0, cpu_stall=0.
- Reset mid-scrub aborts the scrub. The next cycle is ARB with no scrub_done.
- CPU latency: 0 cycles (read data in the same cycle as the grant). Debug ack/read latency: 1 cycle after dbg_gnt.
- CPU gets a stall of at most 1 cycle per debug slot. It is stalled exactly 2**MEM_WIDTH cycles per scrub.
- Worst-case debug wait under continuous CPU traffic: MAX_WAIT cycles, granted in cycle MAX_WAIT+1.
- scrub_busy is high from the cycle after scrub_start through the last scrub write.

## Configuration
- DMEM_ARB_SCRUB_EN defined: SCRUB state, scrub_cnt and the sub-module are present.
- DMEM_ARB_SCRUB_EN undefined: ports remain, scrub_start is ignored, and scrub_busy and scrub_done are tied 0. The FSM is ARB only.

## Structure
- Package dmem_arb_pkg holds:
  - state enum (ARB, SCRUB)
  - default widths DATA_WIDTH/MEM_WIDTH
  - WAIT_W = $clog2(MAX_WAIT+1) helper
  - owner encoding (NONE, CPU, DBG, SCRUB)
- Sub-module dmem_scrub_seq contains the address counter, busy flag and done pulse. It is instantiated only under DMEM_ARB_SCRUB_EN.

## Test plan
- CPU-only traffic:
  - stimulus: CPU write 0xDEADBEEF to addr 3, then read addr 3
  - required: mem_we=1 with addr 3 in cycle 1; cpu_rdata=0xDEADBEEF in cycle 2; cpu_stall=0 throughout
- Debug alone:
  - stimulus: debug read of addr 3 with cpu_req=0
  - required: dbg_gnt in the same cycle; dbg_ack and dbg_rdata=0xDEADBEEF next cycle
- Starvation (MAX_WAIT=4):
  - stimulus: cpu_req held, dbg_req raised at cycle 0
  - required: dbg_gnt and cpu_stall both 1 in cycle 4 only; CPU served again in cycle 5
- Simultaneous requests:
  - stimulus: cpu_req and dbg_req together, wait_cnt=0
  - required: CPU wins; wait_cnt=1 next cycle; debug write does not reach mem
- Scrub (macro on):
  - stimulus: fill addr 0..15 with nonzero data, pulse scrub_start, keep cpu_req high
  - required: cpu_stall for 16 cycles; scrub_done pulses; every address then reads 0
- Reset mid-scrub:
  - stimulus: assert reset at scrub_cnt=7
  - required: scrub_busy=0 next cycle, no scrub_done, addr 8 keeps old data
